// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the KGP mini-RISC datapath: decodes opcode/func and
// sequences FETCH/DECODE/EXEC/MEM/WB with configurable memory wait states and stall support.
module multicycle_control_fsm #(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1,
  parameter int LAT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       imem_en,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] reg_write,
  output logic       imm_mux_ctrl,
  output logic       alu_mux_ctrl,
  output logic [3:0] alu_op,
  output logic       dmem_enable,
  output logic       dmem_write_enable,
  output logic [1:0] reg_write_mux_ctrl,
  output logic [4:0] br_op,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {C_ALU, C_LD, C_ST, C_BR, C_NOP} cls_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  cls_t             cls_q, dec_cls;
  logic             imm_q, amux_q, dec_imm, dec_amux, dec_ill;
  logic [3:0]       aop_q, dec_aop;
  logic [1:0]       rw_q, rwm_q, dec_rw, dec_rwm;
  logic [4:0]       br_q, dec_br;
  logic             fetch_last, mem_last, live, fin;

  always_comb begin
    dec_cls  = C_NOP;
    dec_imm  = 1'b0;
    dec_amux = 1'b0;
    dec_aop  = 4'd0;
    dec_rw   = 2'b00;
    dec_rwm  = 2'd0;
    dec_br   = 5'b00000;
    case (opcode)
      6'd0, 6'd1: if (func <= 6'd1) begin
        dec_cls  = C_ALU;
        dec_aop  = {3'b000, func[0]};
        dec_amux = opcode[0];
      end
      6'd10: if (func <= 6'd1) begin
        dec_cls = C_ALU;
        dec_aop = {3'b001, func[0]};
      end
      // 21 is the variable-shift form of 20
      6'd20, 6'd21: if (func <= 6'd2) begin
        dec_cls = C_ALU;
        dec_aop = {opcode[0], 1'b1, func[1:0]};
      end
      6'd50: begin
        dec_cls = C_ALU;
        dec_aop = 4'd7;
      end
      6'd30: begin
        dec_cls  = C_LD;
        dec_imm  = 1'b1;
        dec_amux = 1'b1;
        dec_rw   = 2'b10;
        dec_rwm  = 2'd1;
      end
      6'd31: begin
        dec_cls  = C_ST;
        dec_imm  = 1'b1;
        dec_amux = 1'b1;
      end
      6'd40: begin dec_cls = C_BR; dec_br = 5'b00001; end
      6'd41: begin dec_cls = C_BR; dec_br = 5'b00101; dec_rw = 2'b11; end
      6'd42: begin dec_cls = C_BR; dec_br = 5'b00100; end
      6'd43: begin dec_cls = C_BR; dec_br = 5'b01100; end
      6'd44: begin dec_cls = C_BR; dec_br = 5'b00010; end
      6'd45: begin dec_cls = C_BR; dec_br = 5'b00011; end
      6'd46: begin dec_cls = C_BR; dec_br = 5'b01011; end
      6'd47: begin dec_cls = C_BR; dec_br = 5'b10011; end
      default: ;
    endcase
    if (dec_cls == C_ALU) begin
      dec_rw  = 2'b01;
      dec_rwm = 2'd2;
    end
    dec_ill = (dec_cls == C_NOP);
  end

  assign fetch_last = (cnt_q == LAT_W'(IMEM_LAT - 1));
  assign mem_last   = (cnt_q == LAT_W'(DMEM_LAT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      FETCH:  if (fetch_last) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC:   state_d = (cls_q == C_ALU) ? WB :
                        (cls_q == C_LD || cls_q == C_ST) ? MEM : FETCH;
      MEM:    if (mem_last) state_d = (cls_q == C_LD) ? WB : FETCH;
      WB:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      cls_q   <= C_NOP;
      imm_q   <= 1'b0;
      amux_q  <= 1'b0;
      aop_q   <= 4'd0;
      rw_q    <= 2'b00;
      rwm_q   <= 2'd0;
      br_q    <= 5'd0;
    end else if (!stall) begin
      // the first unstalled edge after reset only arms the FSM; FETCH starts the cycle after
      if (!run_q) begin
        run_q <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (state_q == DECODE) begin
          cls_q  <= dec_cls;
          imm_q  <= dec_imm;
          amux_q <= dec_amux;
          aop_q  <= dec_aop;
          rw_q   <= dec_rw;
          rwm_q  <= dec_rwm;
          br_q   <= dec_br;
        end else if (state_d == FETCH) begin
          cls_q  <= C_NOP;
          imm_q  <= 1'b0;
          amux_q <= 1'b0;
          aop_q  <= 4'd0;
          rw_q   <= 2'b00;
          rwm_q  <= 2'd0;
          br_q   <= 5'd0;
        end
      end
    end
  end

  assign live = run_q & ~stall;
  assign fin  = ((state_q == EXEC) && (cls_q == C_BR || cls_q == C_NOP)) ||
                ((state_q == MEM) && mem_last && (cls_q == C_ST)) ||
                (state_q == WB);

  always_comb begin
    imem_en           = live && (state_q == FETCH);
    ir_write          = live && (state_q == FETCH) && fetch_last;
    illegal           = live && (state_q == DECODE) && dec_ill;
    dmem_enable       = live && (state_q == MEM);
    dmem_write_enable = live && (state_q == MEM) && (cls_q == C_ST);
    pc_write          = live && fin;
    instr_done        = live && fin;
    reg_write         = (live && (state_q == WB || (state_q == EXEC && cls_q == C_BR))) ? rw_q : 2'b00;
    if (run_q && state_q == DECODE) begin
      imm_mux_ctrl       = dec_imm;
      alu_mux_ctrl       = dec_amux;
      alu_op             = dec_aop;
      reg_write_mux_ctrl = dec_rwm;
      br_op              = dec_br;
    end else begin
      imm_mux_ctrl       = imm_q;
      alu_mux_ctrl       = amux_q;
      alu_op             = aop_q;
      reg_write_mux_ctrl = rwm_q;
      br_op              = br_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-cycle expected output vectors are queued per instruction
// and compared against two differently parameterised instances.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_a = 1'b1, stall_b = 1'b1;
  logic [5:0] op = 6'd0, fn = 6'd0;

  logic imem_a, irw_a, pcw_a, imm_a, amux_a, den_a, dwe_a, done_a, ill_a;
  logic [1:0] rw_a, rwm_a;
  logic [3:0] aop_a;
  logic [4:0] br_a;
  logic imem_b, irw_b, pcw_b, imm_b, amux_b, den_b, dwe_b, done_b, ill_b;
  logic [1:0] rw_b, rwm_b;
  logic [3:0] aop_b;
  logic [4:0] br_b;
  logic [21:0] vec_a, vec_b;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [21:0] KEEP = 22'b00000_111111_00_1111111_00;
  localparam int ALU = 0, LD = 1, ST = 2, BR = 3, NOP = 4;

  typedef struct packed {
    logic       ill;
    logic [2:0] cls;
    logic       imm;
    logic       amux;
    logic [3:0] aop;
    logic [1:0] rw;
    logic [1:0] rwm;
    logic [4:0] br;
  } dec_t;

  typedef struct {
    logic        stall;
    logic        is_dec;
    logic        last;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [21:0] exp;
  } ent_t;

  ent_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.IMEM_LAT(1), .DMEM_LAT(3), .LAT_W(4)) u_a (
    .clk(clk), .rst(rst), .stall(stall_a), .opcode(op), .func(fn),
    .imem_en(imem_a), .ir_write(irw_a), .pc_write(pcw_a), .reg_write(rw_a),
    .imm_mux_ctrl(imm_a), .alu_mux_ctrl(amux_a), .alu_op(aop_a),
    .dmem_enable(den_a), .dmem_write_enable(dwe_a), .reg_write_mux_ctrl(rwm_a),
    .br_op(br_a), .instr_done(done_a), .illegal(ill_a)
  );

  multicycle_control_fsm #(.IMEM_LAT(2), .DMEM_LAT(2), .LAT_W(4)) u_b (
    .clk(clk), .rst(rst), .stall(stall_b), .opcode(op), .func(fn),
    .imem_en(imem_b), .ir_write(irw_b), .pc_write(pcw_b), .reg_write(rw_b),
    .imm_mux_ctrl(imm_b), .alu_mux_ctrl(amux_b), .alu_op(aop_b),
    .dmem_enable(den_b), .dmem_write_enable(dwe_b), .reg_write_mux_ctrl(rwm_b),
    .br_op(br_b), .instr_done(done_b), .illegal(ill_b)
  );

  assign vec_a = {imem_a, irw_a, pcw_a, rw_a, imm_a, amux_a, aop_a, den_a, dwe_a, rwm_a, br_a, done_a, ill_a};
  assign vec_b = {imem_b, irw_b, pcw_b, rw_b, imm_b, amux_b, aop_b, den_b, dwe_b, rwm_b, br_b, done_b, ill_b};

  // Reference decode, written straight from the opcode/func table.
  function automatic dec_t ref_dec(input logic [5:0] o, input logic [5:0] f);
    dec_t d;
    d = '0;
    d.cls = 3'(NOP);
    d.ill = 1'b1;
    if ((o == 0 || o == 1) && f <= 1) begin
      d.cls = 3'(ALU); d.aop = (f == 0) ? 4'd0 : 4'd1; d.amux = (o == 1);
    end else if (o == 10 && f <= 1) begin
      d.cls = 3'(ALU); d.aop = (f == 0) ? 4'd2 : 4'd3;
    end else if (o == 20 && f <= 2) begin
      d.cls = 3'(ALU); d.aop = (f == 0) ? 4'd4 : (f == 1) ? 4'd5 : 4'd6;
    end else if (o == 21 && f <= 2) begin
      d.cls = 3'(ALU); d.aop = (f == 0) ? 4'd12 : (f == 1) ? 4'd13 : 4'd14;
    end else if (o == 50) begin
      d.cls = 3'(ALU); d.aop = 4'd7;
    end else if (o == 30) begin
      d.cls = 3'(LD); d.imm = 1; d.amux = 1; d.rw = 2'b10; d.rwm = 2'd1;
    end else if (o == 31) begin
      d.cls = 3'(ST); d.imm = 1; d.amux = 1;
    end else if (o >= 40 && o <= 47) begin
      d.cls = 3'(BR);
      case (o)
        6'd40: d.br = 5'b00001;
        6'd41: begin d.br = 5'b00101; d.rw = 2'b11; end
        6'd42: d.br = 5'b00100;
        6'd43: d.br = 5'b01100;
        6'd44: d.br = 5'b00010;
        6'd45: d.br = 5'b00011;
        6'd46: d.br = 5'b01011;
        default: d.br = 5'b10011;
      endcase
    end
    if (d.cls == 3'(ALU)) begin
      d.rw = 2'b01; d.rwm = 2'd2;
    end
    if (d.cls != 3'(NOP)) d.ill = 1'b0;
    return d;
  endfunction

  function automatic logic [21:0] mk(input logic imem, irw, pcw, input logic [1:0] rw,
                                     input dec_t d, input logic use_d,
                                     input logic den, dwe, done, ill);
    logic [21:0] v;
    v = {imem, irw, pcw, rw, 1'b0, 1'b0, 4'd0, den, dwe, 2'd0, 5'd0, done, ill};
    if (use_d) begin
      v[16] = d.imm; v[15] = d.amux; v[14:11] = d.aop; v[8:7] = d.rwm; v[6:2] = d.br;
    end
    return v;
  endfunction

  // Queue the expected per-cycle outputs of one instruction, with st_len stalled
  // copies of cycle st_at inserted ahead of it (st_at < 0: no stall).
  task automatic push_instr(input int ilat, input int dlat, input logic [5:0] o,
                            input logic [5:0] f, input int st_at, input int st_len);
    dec_t d;
    logic [21:0] base[$];
    logic isd[$];
    ent_t e;
    logic lastm;
    d = ref_dec(o, f);
    for (int i = 0; i < ilat; i++) begin
      base.push_back(mk(1, i == ilat - 1, 0, 2'b00, d, 0, 0, 0, 0, 0)); isd.push_back(0);
    end
    base.push_back(mk(0, 0, 0, 2'b00, d, 1, 0, 0, 0, d.ill)); isd.push_back(1);
    if (d.cls == 3'(BR) || d.cls == 3'(NOP))
      base.push_back(mk(0, 0, 1, d.rw, d, 1, 0, 0, 1, 0));
    else
      base.push_back(mk(0, 0, 0, 2'b00, d, 1, 0, 0, 0, 0));
    isd.push_back(0);
    if (d.cls == 3'(LD) || d.cls == 3'(ST)) begin
      for (int j = 0; j < dlat; j++) begin
        lastm = (j == dlat - 1) && (d.cls == 3'(ST));
        base.push_back(mk(0, 0, lastm, 2'b00, d, 1, 1, d.cls == 3'(ST), lastm, 0)); isd.push_back(0);
      end
    end
    if (d.cls == 3'(ALU) || d.cls == 3'(LD)) begin
      base.push_back(mk(0, 0, 1, d.rw, d, 1, 0, 0, 1, 0)); isd.push_back(0);
    end
    for (int k = 0; k < base.size(); k++) begin
      e.op = o; e.fn = f; e.is_dec = isd[k]; e.last = 0;
      if (k == st_at) begin
        for (int s = 0; s < st_len; s++) begin
          e.stall = 1; e.exp = base[k] & KEEP; sb.push_back(e);
        end
      end
      e.stall = 0; e.exp = base[k]; e.last = (k == base.size() - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_sb(input logic sel, input int n);
    ent_t e;
    logic [21:0] got;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      e = sb.pop_front();
      @(negedge clk);
      if (sel) stall_b = e.stall; else stall_a = e.stall;
      if (e.is_dec) begin
        op = e.op; fn = e.fn;
      end else begin
        op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63));
      end
      #1;
      got = sel ? vec_b : vec_a;
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL cycle dut=%0d op=%0d func=%0d stall=%0b: got %h, expected %h",
                 sel, e.op, e.fn, e.stall, got, e.exp);
      end
      if (e.last) $display("instr dut=%0d op=%0d func=%0d retired", sel, e.op, e.fn);
    end
  endtask

  task automatic do_reset(input logic sel);
    @(negedge clk);
    rst = 1; stall_a = 1; stall_b = 1;
    #1;
    vectors += 2;
    if (vec_a !== 22'd0) begin
      miscompares++; $display("FAIL reset_a: got %h, expected 0", vec_a);
    end
    if (vec_b !== 22'd0) begin
      miscompares++; $display("FAIL reset_b: got %h, expected 0", vec_b);
    end
    @(negedge clk);
    rst = 0;
    if (sel) stall_b = 0; else stall_a = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
  endtask

  task automatic test_alu();
    push_instr(1, 3, 6'd0, 6'd0, -1, 0);
    push_instr(1, 3, 6'd0, 6'd1, -1, 0);
    push_instr(1, 3, 6'd1, 6'd0, -1, 0);
    push_instr(1, 3, 6'd1, 6'd1, -1, 0);
    push_instr(1, 3, 6'd10, 6'd1, -1, 0);
    push_instr(1, 3, 6'd20, 6'd1, -1, 0);
    push_instr(1, 3, 6'd21, 6'd2, -1, 0);
    push_instr(1, 3, 6'd50, 6'd33, -1, 0);
    run_sb(0, 1000);
  endtask

  task automatic test_lw();
    push_instr(1, 3, 6'd30, 6'd0, -1, 0);
    run_sb(0, 1000);
  endtask

  task automatic test_branch();
    push_instr(1, 3, 6'd41, 6'd0, -1, 0);
    push_instr(1, 3, 6'd40, 6'd7, -1, 0);
    push_instr(1, 3, 6'd43, 6'd0, -1, 0);
    push_instr(1, 3, 6'd47, 6'd0, -1, 0);
    run_sb(0, 1000);
  endtask

  task automatic test_illegal();
    push_instr(1, 3, 6'd63, 6'd0, -1, 0);
    push_instr(1, 3, 6'd0, 6'd5, -1, 0);
    push_instr(1, 3, 6'd20, 6'd3, -1, 0);
    run_sb(0, 1000);
  endtask

  task automatic test_reset_mid();
    push_instr(1, 3, 6'd30, 6'd0, -1, 0);
    run_sb(0, 5);
    sb.delete();
    @(negedge clk);
    rst = 1;
    #1;
    vectors++;
    if (vec_a !== 22'd0) begin
      miscompares++; $display("FAIL reset_mid_mem: got %h, expected 0", vec_a);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (vec_a !== 22'd0) begin
      miscompares++; $display("FAIL reset_mid_hold: got %h, expected 0", vec_a);
    end
    rst = 0;
    push_instr(1, 3, 6'd0, 6'd0, -1, 0);
    run_sb(0, 1000);
  endtask

  task automatic test_sw_stall();
    do_reset(1);
    push_instr(2, 2, 6'd31, 6'd0, 5, 2);
    push_instr(2, 2, 6'd30, 6'd0, 2, 1);
    run_sb(1, 1000);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [14];
    logic [5:0] o;
    ops = '{6'd0, 6'd1, 6'd10, 6'd20, 6'd21, 6'd50, 6'd30, 6'd31,
            6'd40, 6'd41, 6'd44, 6'd46, 6'd63, 6'd12};
    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 1) == 1)
        push_instr(2, 2, o, 6'($urandom_range(0, 2)), $urandom_range(0, 5), $urandom_range(1, 3));
      else
        push_instr(2, 2, o, 6'($urandom_range(0, 2)), -1, 0);
    end
    run_sb(1, 10000);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_sw_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
